// File: rtl/tt_pwm_bank.sv
// ---------------------------------------------------------------------------
// tt_pwm_bank - multi-channel PWM generator core
//
// A shared prescaler advances a shared WIDTH-bit period counter. Each channel
// compares the counter against its active duty value. Duty values are written
// into shadow registers and copied to the active set only at the counter wrap,
// so a running period is never cut short or lengthened by a write.
//
// Optional feature macro: PWM_PHASE_STAGGER_EN
//   When defined, channel i compares (cnt + i*(2^WIDTH/CHANNELS)) mod 2^WIDTH
//   instead of cnt, spreading the channel edges across the period. The wrap,
//   the shadow transfer and period_tick always follow the unstaggered counter.
//
// Register map (cfg_addr):
//   0 .. CHANNELS-1  duty shadow of channel addr
//   CHANNELS         prescale (applies at once)
//   CHANNELS+1       enable mask, cfg_data[CHANNELS-1:0] (applies at once)
//   others           unmapped: write is absorbed and cfg_err pulses
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   ena          global enable; low freezes prescaler and counter
//   cfg_valid    write request
//   cfg_ready    core can accept a write (low for one cycle after an accept)
//   cfg_addr     register address, ADDR_W bits
//   cfg_data     write data, WIDTH bits
//   cfg_err      one-cycle pulse after an accepted unmapped write
//   pwm_out      registered PWM outputs, one per channel
//   period_tick  one-cycle pulse on counter wrap
// ---------------------------------------------------------------------------
module tt_pwm_bank #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 8,
    localparam int ADDR_W  = $clog2(CHANNELS + 2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [WIDTH-1:0]    cfg_data,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
`ifdef PWM_PHASE_STAGGER_EN
    localparam int STAGGER = (1 << WIDTH) / CHANNELS;
`endif

    logic                ready_q;
    logic                err_q, err_d;
    logic [WIDTH-1:0]    pcnt_q, pcnt_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    prescale_q;
    logic [CHANNELS-1:0] en_mask_q;
    logic                ptick_q;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic [WIDTH-1:0]    duty_shadow_q [CHANNELS];
    logic [WIDTH-1:0]    duty_active_q [CHANNELS];
    logic [WIDTH-1:0]    phase_cnt     [CHANNELS];

    logic accept;
    logic sel_prescale;
    logic sel_mask;
    logic unmapped;
    logic tick;
    logic wrap;

    assign accept       = cfg_valid && ready_q;
    assign sel_prescale = (cfg_addr == ADDR_W'(CHANNELS));
    assign sel_mask     = (cfg_addr == ADDR_W'(CHANNELS + 1));
    assign unmapped     = (cfg_addr >  ADDR_W'(CHANNELS + 1));

    // >= rather than == so that lowering prescale below the running pcnt
    // ticks right away instead of running pcnt all the way round.
    assign tick = ena && (pcnt_q >= prescale_q);
    assign wrap = tick && (cnt_q == CNT_MAX);

    always_comb begin
        pcnt_d = pcnt_q;
        if (ena) begin
            pcnt_d = tick ? '0 : pcnt_q + WIDTH'(1);
        end
        cnt_d = tick ? cnt_q + WIDTH'(1) : cnt_q;
        err_d = accept && unmapped;
    end

    // Per-channel compare; uses the pre-edge counter, so pwm_out lags cnt
    // by one clock.
    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
`ifdef PWM_PHASE_STAGGER_EN
            phase_cnt[i] = cnt_q + WIDTH'(i * STAGGER);
`else
            phase_cnt[i] = cnt_q;
`endif
            pwm_d[i] = en_mask_q[i] && (phase_cnt[i] < duty_active_q[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q    <= 1'b1;
            err_q      <= 1'b0;
            pcnt_q     <= '0;
            cnt_q      <= '0;
            prescale_q <= '0;
            en_mask_q  <= '0;
            ptick_q    <= 1'b0;
            pwm_q      <= '0;
        end else begin
            // Ready drops for exactly one cycle after each accept.
            ready_q <= !accept;
            err_q   <= err_d;
            pcnt_q  <= pcnt_d;
            cnt_q   <= cnt_d;
            ptick_q <= wrap;
            pwm_q   <= pwm_d;
            if (accept && sel_prescale) begin
                prescale_q <= cfg_data;
            end
            if (accept && sel_mask) begin
                en_mask_q <= cfg_data[CHANNELS-1:0];
            end
        end
    end

    // Shadow transfer reads the pre-edge shadow, so a write landing on the
    // wrap edge is only picked up at the following wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                duty_shadow_q[i] <= '0;
                duty_active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wrap) begin
                    duty_active_q[i] <= duty_shadow_q[i];
                end
                if (accept && (cfg_addr == ADDR_W'(i))) begin
                    duty_shadow_q[i] <= cfg_data;
                end
            end
        end
    end

    assign cfg_ready   = ready_q;
    assign cfg_err     = err_q;
    assign pwm_out     = pwm_q;
    assign period_tick = ptick_q;

endmodule

// File: tb/tb_tt_pwm_bank.sv
// ---------------------------------------------------------------------------
// tb_tt_pwm_bank - self-checking bench for tt_pwm_bank (CHANNELS=8, WIDTH=8)
//
// A behavioural model (integer counters, modular arithmetic) predicts every
// registered output; a compare process checks it on each falling edge.
// Directed sequences additionally pin measured quantities (high counts per
// period, tick spacing, handshake patterns) to hand-computed literals.
// ---------------------------------------------------------------------------
module tb_tt_pwm_bank;

    localparam int CH     = 8;
    localparam int W      = 8;
    localparam int PER    = 1 << W;
    localparam int ADDR_W = $clog2(CH + 2);
`ifdef PWM_PHASE_STAGGER_EN
    localparam int STG    = PER / CH;
`else
    localparam int STG    = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              ena;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [ADDR_W-1:0] cfg_addr;
    logic [W-1:0]      cfg_data;
    logic              cfg_err;
    logic [CH-1:0]     pwm_out;
    logic              period_tick;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    tt_pwm_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_err     (cfg_err),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int            m_pcnt, m_cnt, m_pre;
    int            m_sh  [CH];
    int            m_act [CH];
    logic [CH-1:0] m_mask;
    logic          m_ready;
    logic [CH-1:0] e_pwm;
    logic          e_tick, e_err;
    logic          m_acc, m_tck, m_wrp;
    logic [CH-1:0] m_pwm_next;

    assign m_acc = cfg_valid && m_ready;
    assign m_tck = ena && (m_pcnt >= m_pre);
    assign m_wrp = m_tck && (m_cnt == PER - 1);

    always_comb begin
        m_pwm_next = '0;
        for (int i = 0; i < CH; i++)
            m_pwm_next[i] = m_mask[i] && (((m_cnt + i * STG) % PER) < m_act[i]);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pcnt  <= 0;
            m_cnt   <= 0;
            m_pre   <= 0;
            m_mask  <= '0;
            m_ready <= 1'b1;
            e_pwm   <= '0;
            e_tick  <= 1'b0;
            e_err   <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                m_sh[i]  <= 0;
                m_act[i] <= 0;
            end
        end else begin
            if (ena) m_pcnt <= m_tck ? 0 : m_pcnt + 1;
            if (m_tck) m_cnt <= (m_cnt + 1) % PER;
            for (int i = 0; i < CH; i++) begin
                if (m_wrp) m_act[i] <= m_sh[i];
                if (m_acc && int'(cfg_addr) == i) m_sh[i] <= int'(cfg_data);
            end
            if (m_acc && int'(cfg_addr) == CH)     m_pre  <= int'(cfg_data);
            if (m_acc && int'(cfg_addr) == CH + 1) m_mask <= cfg_data[CH-1:0];
            m_ready <= !m_acc;
            e_pwm   <= m_pwm_next;
            e_tick  <= m_wrp;
            e_err   <= m_acc && (int'(cfg_addr) > CH + 1);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pwm",   int'(pwm_out),     int'(e_pwm));
            check("model_tick",  int'(period_tick), int'(e_tick));
            check("model_err",   int'(cfg_err),     int'(e_err));
            check("model_ready", int'(cfg_ready),   int'(m_ready));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input int a, input int d);
        int w = 0;
        while (!cfg_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        cfg_valid = 1'b1;
        cfg_addr  = ADDR_W'(a);
        cfg_data  = W'(d);
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < budget);
        if (n >= budget) check("tick_timeout", int'(period_tick), 1);
    endtask

    task automatic count_win(input int n, output int c0, output int co);
        c0 = 0;
        co = 0;
        for (int k = 0; k < n; k++) begin
            if (pwm_out[0]) c0++;
            if (pwm_out[CH-1:1] != '0) co++;
            @(negedge clk);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c0, co, c0b, cob;
        rst       = 1'b1;
        ena       = 1'b1;
        cfg_valid = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pwm",   int'(pwm_out),     0);
        check("rst_ready", int'(cfg_ready),   1);
        check("rst_tick",  int'(period_tick), 0);
        check("rst_err",   int'(cfg_err),     0);
        rst = 1'b0;
        wait_tick(2000, n);
        check("first_tick_clocks", n, 256);

        // Basic duty
        wr(0, 64);
        wr(CH + 1, 8'h01);
        wait_tick(2000, n);
        count_win(256, c0, co);
        check("basic_high64", c0, 64);
        check("basic_others0", co, 0);

        // Shadowing: write 128 at cnt=10, current period keeps 64
        fork
            count_win(256, c0, co);
            begin
                repeat (10) @(negedge clk);
                wr(0, 128);
            end
        join
        check("shadow_cur64", c0, 64);
        count_win(256, c0, co);
        check("shadow_next128", c0, 128);

        // Write coincident with the wrap edge: old shadow (128) transfers
        repeat (255) @(negedge clk);
        wr(0, 200);
        check("coinc_is_wrap", int'(period_tick), 1);
        count_win(256, c0, co);
        check("coinc_old128", c0, 128);
        count_win(256, c0, co);
        check("coinc_then200", c0, 200);

        // Handshake: valid held 3 cycles on an unmapped address
        @(negedge clk);
        cfg_addr  = ADDR_W'(10);
        cfg_data  = 8'hFF;
        cfg_valid = 1'b1;
        check("hs_rdy_c0", int'(cfg_ready), 1);
        check("hs_err_c0", int'(cfg_err),   0);
        @(negedge clk);
        check("hs_rdy_c1", int'(cfg_ready), 0);
        check("hs_err_c1", int'(cfg_err),   1);
        @(negedge clk);
        check("hs_rdy_c2", int'(cfg_ready), 1);
        check("hs_err_c2", int'(cfg_err),   0);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("hs_rdy_c3", int'(cfg_ready), 0);
        check("hs_err_c3", int'(cfg_err),   1);
        @(negedge clk);
        check("hs_rdy_c4", int'(cfg_ready), 1);
        check("hs_err_c4", int'(cfg_err),   0);

        // Single unmapped write: one-cycle error, nothing changes
        wr(CH + 2, 8'h3C);
        check("err_pulse_hi", int'(cfg_err), 1);
        @(negedge clk);
        check("err_pulse_lo", int'(cfg_err), 0);
        wait_tick(2000, n);
        count_win(256, c0, co);
        check("err_duty_kept", c0, 200);
        check("err_mask_kept", co, 0);

        // Prescale = 3: 1024 clocks per period
        wr(CH, 3);
        wait_tick(3000, n);
        wait_tick(3000, n);
        check("prescale3_period", n, 1024);

        // ena low for 100 clocks delays the next tick by exactly 100
        repeat (50) @(negedge clk);
        ena = 1'b0;
        repeat (100) @(negedge clk);
        ena = 1'b1;
        wait_tick(3000, n);
        check("ena_delay_period", n + 150, 1124);

        // Boundary duties at prescale 0
        wr(CH, 0);
        wr(0, 0);
        wait_tick(3000, n);
        wait_tick(3000, n);
        check("p0_period", n, 256);
        count_win(256, c0, co);
        check("duty0_const_low", c0, 0);
        wr(0, 255);
        wait_tick(3000, n);
        wait_tick(3000, n);
        count_win(256, c0, co);
        check("duty255_one_low", c0, 255);
        count_win(256, c0b, cob);
        check("duty255_one_low_b", c0b, 255);

        // Asynchronous reset mid-period with duty 64 active
        wr(0, 64);
        wait_tick(3000, n);
        wait_tick(3000, n);
        repeat (5) @(negedge clk);
        check("pre_rst_pwm0", int'(pwm_out[0]), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pwm",   int'(pwm_out),     0);
        check("async_rst_ready", int'(cfg_ready),   1);
        check("async_rst_tick",  int'(period_tick), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_tick(2000, n);
        check("post_rst_first_tick", n, 256);

`ifdef PWM_PHASE_STAGGER_EN
        begin
            int            t [CH];
            logic [CH-1:0] prev;
            for (int i = 0; i < CH; i++) wr(i, 128);
            wr(CH + 1, 8'hFF);
            wait_tick(2000, n);
            wait_tick(2000, n);
            for (int i = 0; i < CH; i++) t[i] = -1;
            prev = pwm_out;
            for (int k = 0; k < 256; k++) begin
                @(negedge clk);
                for (int i = 0; i < CH; i++)
                    if (!prev[i] && pwm_out[i] && t[i] < 0) t[i] = k;
                prev = pwm_out;
            end
            // Channel i sees cnt advanced by 32*i, so it rises 32*i clocks
            // before channel 0, i.e. (256 - 32*i) mod 256 after it.
            for (int i = 1; i < CH; i++)
                check($sformatf("stagger_ch%0d", i),
                      (((t[i] - t[0]) % 256) + 256) % 256, (256 - 32 * i) % 256);
        end
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
